// File: rtl/config_select.sv
// Configuration front-end: synchronises and debounces the board switches, commits
// a stable value to the address decoder and holds the CPU in reset while it changes.
module config_select #(
    parameter int DEBOUNCE_CYCLES = 65536,
    parameter int CPU_RESET_HOLD  = 1024,
    parameter int CONFIG_BITS     = 4
) (
    input  logic                   fpga_clk,
    input  logic                   resetbar,
    input  logic [CONFIG_BITS-1:0] config_sw,
    input  logic                   reload_req,
    output logic [CONFIG_BITS-1:0] configuration,
    output logic                   config_valid,
    output logic                   config_strobe,
    output logic                   cpu_resetbar
);

    localparam int CNT_W  = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam int HCNT_W = (CPU_RESET_HOLD > 1) ? $clog2(CPU_RESET_HOLD) : 1;

    localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);
    localparam logic [HCNT_W-1:0] HCNT_LAST = HCNT_W'(CPU_RESET_HOLD - 1);
    localparam logic [HCNT_W-1:0] HCNT_ONE  = HCNT_W'(1);

    typedef enum logic [1:0] {
        SAMPLE = 2'd0,
        HOLD   = 2'd1,
        RUN    = 2'd2
    } state_t;

    state_t                   state;
    state_t                   state_next;
    logic [CONFIG_BITS-1:0]   s1;
    logic [CONFIG_BITS-1:0]   s2;
    logic [CONFIG_BITS-1:0]   cand;
    logic [CONFIG_BITS-1:0]   cand_next;
    logic [CNT_W-1:0]         cnt;
    logic [CNT_W-1:0]         cnt_next;
    logic [HCNT_W-1:0]        hcnt;
    logic [HCNT_W-1:0]        hcnt_next;
    logic [CONFIG_BITS-1:0]   configuration_next;
    logic                     config_valid_next;
    logic                     config_strobe_next;
    logic                     cpu_resetbar_next;

    // Two-flop synchroniser; the raw switches are never looked at past this point.
    always_ff @(posedge fpga_clk or negedge resetbar) begin
        if (!resetbar) begin
            s1 <= '0;
            s2 <= '0;
        end else begin
            s1 <= config_sw;
            s2 <= s1;
        end
    end

    always_ff @(posedge fpga_clk or negedge resetbar) begin
        if (!resetbar) begin
            state         <= SAMPLE;
            cand          <= '0;
            cnt           <= '0;
            hcnt          <= '0;
            configuration <= '0;
            config_valid  <= 1'b0;
            config_strobe <= 1'b0;
            cpu_resetbar  <= 1'b0;
        end else begin
            state         <= state_next;
            cand          <= cand_next;
            cnt           <= cnt_next;
            hcnt          <= hcnt_next;
            configuration <= configuration_next;
            config_valid  <= config_valid_next;
            config_strobe <= config_strobe_next;
            cpu_resetbar  <= cpu_resetbar_next;
        end
    end

    always_comb begin
        state_next         = state;
        cand_next          = cand;
        cnt_next           = cnt;
        hcnt_next          = hcnt;
        configuration_next = configuration;
        config_valid_next  = config_valid;
        config_strobe_next = 1'b0;
        cpu_resetbar_next  = cpu_resetbar;

        case (state)
            SAMPLE: begin
                // A change on the terminal count edge restarts rather than commits.
                if (s2 != cand) begin
                    cand_next = s2;
                    cnt_next  = '0;
                end else if (cnt == CNT_LAST) begin
                    configuration_next = cand;
                    config_valid_next  = 1'b1;
                    config_strobe_next = 1'b1;
                    cpu_resetbar_next  = 1'b0;
                    hcnt_next          = '0;
                    state_next         = HOLD;
                end else begin
                    cnt_next = cnt + CNT_ONE;
                end
            end

            HOLD: begin
                // Counter stops at its last value instead of wrapping.
                if (hcnt == HCNT_LAST) begin
                    cpu_resetbar_next = 1'b1;
                    state_next        = RUN;
                end else begin
                    hcnt_next = hcnt + HCNT_ONE;
                end
            end

            RUN: begin
                if (reload_req || (s2 != configuration)) begin
                    state_next = SAMPLE;
                    cand_next  = s2;
                    cnt_next   = '0;
                end
            end

            default: begin
                state_next = SAMPLE;
            end
        endcase
    end

endmodule

// File: tb/tb_config_select.sv
// Self-checking bench for config_select: scoreboard of expected commits and CPU
// releases, checked against the edge number at which the DUT produces them.
module tb_config_select;

    localparam int D = 8;
    localparam int H = 4;

    logic       fpga_clk;
    logic       resetbar;
    logic [3:0] config_sw;
    logic       reload_req;
    logic [3:0] configuration;
    logic       config_valid;
    logic       config_strobe;
    logic       cpu_resetbar;

    int n_checks;
    int n_fail;
    int edge_cnt;

    logic [3:0] exp_cfg_q[$];
    int         exp_edge_q[$];
    int         exp_rel_q[$];

    logic [3:0] model_cfg;
    logic       valid_seen;
    logic       prev_cpu;
    logic       fall_valid;
    int         fall_edge;

    config_select #(
        .DEBOUNCE_CYCLES(D),
        .CPU_RESET_HOLD (H),
        .CONFIG_BITS    (4)
    ) dut (
        .fpga_clk      (fpga_clk),
        .resetbar      (resetbar),
        .config_sw     (config_sw),
        .reload_req    (reload_req),
        .configuration (configuration),
        .config_valid  (config_valid),
        .config_strobe (config_strobe),
        .cpu_resetbar  (cpu_resetbar)
    );

    // Clock and edge numbering: edge 1 is the first rising edge after release.
    initial fpga_clk = 1'b0;
    always #5 fpga_clk = ~fpga_clk;

    always @(posedge fpga_clk or negedge resetbar) begin
        if (!resetbar) edge_cnt <= 0;
        else           edge_cnt <= edge_cnt + 1;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (edge %0d)", tag, got, exp, edge_cnt);
        end
    endtask

    task automatic push_commit(input logic [3:0] cfg, input int commit_edge);
        exp_cfg_q.push_back(cfg);
        exp_edge_q.push_back(commit_edge);
        exp_rel_q.push_back(commit_edge + H);
    endtask

    task automatic run_to_edge(input int target);
        for (int i = 0; i < 1000 && edge_cnt < target; i++) @(negedge fpga_clk);
        if (edge_cnt < target) check_eq("edge_timeout", edge_cnt, target);
    endtask

    // Called at a falling edge; asserts reset, checks outputs, releases with sw applied.
    task automatic do_reset(input logic [3:0] sw);
        #2;
        resetbar  = 1'b0;
        config_sw = sw;
        #1;
        check_eq("rst_configuration", configuration, 4'h0);
        check_eq("rst_config_valid",  config_valid,  1'b0);
        check_eq("rst_config_strobe", config_strobe, 1'b0);
        check_eq("rst_cpu_resetbar",  cpu_resetbar,  1'b0);
        exp_cfg_q.delete();
        exp_edge_q.delete();
        exp_rel_q.delete();
        model_cfg  = 4'h0;
        valid_seen = 1'b0;
        prev_cpu   = 1'b0;
        fall_valid = 1'b0;
        repeat (2) @(negedge fpga_clk);
        #2;
        resetbar = 1'b1;
        push_commit(sw, (sw == 4'h0) ? D : D + 3);
    endtask

    // Monitor / scoreboard, sampled on the falling edge.
    always @(negedge fpga_clk) begin
        if (resetbar) begin
            if (config_strobe) begin
                if (exp_cfg_q.size() == 0) begin
                    check_eq("unexp_strobe", 1, 0);
                end else begin
                    logic [3:0] ecfg;
                    int         eedge;
                    ecfg  = exp_cfg_q.pop_front();
                    eedge = exp_edge_q.pop_front();
                    check_eq("commit_cfg",     configuration, ecfg);
                    check_eq("commit_edge",    edge_cnt,      eedge);
                    check_eq("commit_valid",   config_valid,  1'b1);
                    check_eq("commit_cpu_low", cpu_resetbar,  1'b0);
                    model_cfg  = ecfg;
                    valid_seen = 1'b1;
                end
            end
            check_eq("cfg_stable", configuration, model_cfg);
            check_eq("valid_level", config_valid, valid_seen);
            if (prev_cpu && !cpu_resetbar) begin
                fall_edge  = edge_cnt;
                fall_valid = 1'b1;
                check_eq("fall_with_strobe", config_strobe, 1'b1);
            end
            if (!prev_cpu && cpu_resetbar) begin
                if (exp_rel_q.size() == 0) check_eq("unexp_release", 1, 0);
                else                       check_eq("release_edge", edge_cnt, exp_rel_q.pop_front());
                if (fall_valid) check_eq("hold_len", edge_cnt - fall_edge, H);
            end
            prev_cpu = cpu_resetbar;
        end
    end

    initial begin
        int n;
        n_checks   = 0;
        n_fail     = 0;
        resetbar   = 1'b0;
        config_sw  = 4'h0;
        reload_req = 1'b0;
        model_cfg  = 4'h0;
        valid_seen = 1'b0;
        prev_cpu   = 1'b0;
        fall_valid = 1'b0;
        fall_edge  = 0;

        // Initial commit with all switches off: commit 8, release 12.
        @(negedge fpga_clk);
        do_reset(4'h0);
        run_to_edge(16);

        // Initial commit with 5: commit 11, release 15.
        do_reset(4'h5);
        run_to_edge(20);

        // Bouncing 5->A->5->A every 3 cycles, then hold A.
        config_sw = 4'hA;
        repeat (3) @(negedge fpga_clk);
        config_sw = 4'h5;
        repeat (3) @(negedge fpga_clk);
        n = edge_cnt;
        config_sw = 4'hA;
        push_commit(4'hA, n + 3 + D);
        run_to_edge(n + 3 + D + H + 4);

        // Runtime change back to 5.
        n = edge_cnt;
        config_sw = 4'h5;
        push_commit(4'h5, n + 3 + D);
        run_to_edge(n + 3 + D + H + 4);

        // Reload with unchanged switches, then a reload during HOLD that must be ignored.
        n = edge_cnt;
        reload_req = 1'b1;
        @(negedge fpga_clk);
        reload_req = 1'b0;
        push_commit(4'h5, n + 1 + D);
        run_to_edge(n + 1 + D + 1);
        check_eq("in_hold_cpu", cpu_resetbar, 1'b0);
        reload_req = 1'b1;
        @(negedge fpga_clk);
        reload_req = 1'b0;
        run_to_edge(n + 1 + D + H + 12);

        // Change to A, then reset while the CPU is held; full sequence repeats.
        n = edge_cnt;
        config_sw = 4'hA;
        push_commit(4'hA, n + 3 + D);
        run_to_edge(n + 3 + D + 2);
        check_eq("mid_hold_cpu", cpu_resetbar, 1'b0);
        check_eq("mid_hold_cfg", configuration, 4'hA);
        do_reset(4'hA);
        run_to_edge(20);

        check_eq("cfg_q_empty", exp_cfg_q.size(), 0);
        check_eq("rel_q_empty", exp_rel_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
